// File: rtl/dma_fifo_ctrl.sv
// Circular-FIFO sequencer over DEPTH external single-word DMA slots; one slot access in flight.
// Latency: write 2 cycles, read 3 edges to pop_valid; backpressure: push_ready/pop_ready drop while busy, pop wins over push.
module dma_fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DW-1:0]    push_data,
    output logic             push_ready,
    input  logic             pop,
    output logic             pop_ready,
    output logic             pop_valid,
    output logic [DW-1:0]    pop_data,
    output logic [DEPTH-1:0] slot_en,
    output logic             slot_wr_rd,
    output logic [DW-1:0]    slot_wdata,
    input  logic [DW-1:0]    slot_rdata,
    input  logic [DEPTH-1:0] slot_flag,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             err,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [DEPTH-1:0] EN_ONE   = DEPTH'(1);

    state_e           state_q,      state_d;
    logic [AW-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [AW-1:0]    acc_ptr_q,    acc_ptr_d;
    logic [AW:0]      count_q,      count_d;
    logic             full_q,       full_d;
    logic             empty_q,      empty_d;
    logic             err_q,        err_d;
    logic             pop_valid_q,  pop_valid_d;
    logic [DW-1:0]    pop_data_q,   pop_data_d;
    logic [DEPTH-1:0] slot_en_q,    slot_en_d;
    logic             slot_wr_rd_q, slot_wr_rd_d;
    logic [DW-1:0]    slot_wdata_q, slot_wdata_d;
    logic             wr_chk_q,     wr_chk_d;

    logic push_acc;
    logic pop_acc;
    logic err_set;

    assign pop_ready  = (state_q == IDLE) && !empty_q;
    assign push_ready = (state_q == IDLE) && !full_q && !(pop && !empty_q);
    assign push_acc   = push && push_ready;
    assign pop_acc    = pop && pop_ready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        acc_ptr_d    = acc_ptr_q;
        count_d      = count_q;
        pop_valid_d  = 1'b0;
        pop_data_d   = pop_data_q;
        slot_en_d    = '0;
        slot_wr_rd_d = slot_wr_rd_q;
        slot_wdata_d = slot_wdata_q;
        wr_chk_d     = 1'b0;
        err_set      = 1'b0;

        // Write completion is verified one cycle after the slot sampled it.
        if (wr_chk_q && !slot_flag[acc_ptr_q]) begin
            err_set = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pop_acc) begin
                    acc_ptr_d    = rd_ptr_q;
                    rd_ptr_d     = rd_ptr_q + PTR_ONE;
                    count_d      = count_q - CNT_ONE;
                    slot_en_d    = EN_ONE << rd_ptr_q;
                    slot_wr_rd_d = 1'b0;
                    state_d      = READ;
                end else if (push_acc) begin
                    acc_ptr_d    = wr_ptr_q;
                    wr_ptr_d     = wr_ptr_q + PTR_ONE;
                    count_d      = count_q + CNT_ONE;
                    slot_en_d    = EN_ONE << wr_ptr_q;
                    slot_wr_rd_d = 1'b1;
                    slot_wdata_d = push_data;
                    state_d      = WRITE;
                end
                // A push stalled behind an accepted pop becomes acceptable next, so it is not flagged.
                if ((push && full_q && !pop_acc) || (pop && empty_q)) begin
                    err_set = 1'b1;
                end
            end
            WRITE: begin
                wr_chk_d = 1'b1;
                state_d  = IDLE;
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                pop_data_d  = slot_rdata;
                pop_valid_d = 1'b1;
                if (slot_flag[acc_ptr_q]) begin
                    err_set = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
        err_d   = err_clr ? 1'b0 : (err_q || err_set);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            acc_ptr_q    <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            err_q        <= 1'b0;
            pop_valid_q  <= 1'b0;
            pop_data_q   <= '0;
            slot_en_q    <= '0;
            slot_wr_rd_q <= 1'b0;
            slot_wdata_q <= '0;
            wr_chk_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            acc_ptr_q    <= acc_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            err_q        <= err_d;
            pop_valid_q  <= pop_valid_d;
            pop_data_q   <= pop_data_d;
            slot_en_q    <= slot_en_d;
            slot_wr_rd_q <= slot_wr_rd_d;
            slot_wdata_q <= slot_wdata_d;
            wr_chk_q     <= wr_chk_d;
        end
    end

    assign pop_valid  = pop_valid_q;
    assign pop_data   = pop_data_q;
    assign slot_en    = slot_en_q;
    assign slot_wr_rd = slot_wr_rd_q;
    assign slot_wdata = slot_wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign err        = err_q;

    a_slot_en_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(slot_en_q));
    a_count_range:    assert property (@(posedge clk) disable iff (!rst) count_q <= CNT_FULL);

endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// Bench for dma_fifo_ctrl: slot-bank model plus a queue-based reference of FIFO contents.
module tb_dma_fifo_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             push, pop, err_clr;
    logic [DW-1:0]    push_data;
    logic             push_ready, pop_ready, pop_valid;
    logic [DW-1:0]    pop_data;
    logic [DEPTH-1:0] slot_en;
    logic             slot_wr_rd;
    logic [DW-1:0]    slot_wdata, slot_rdata;
    logic [DEPTH-1:0] slot_flag;
    logic [AW:0]      count;
    logic             full, empty, err;

    dma_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_data(push_data), .push_ready(push_ready),
        .pop(pop), .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_data(pop_data),
        .slot_en(slot_en), .slot_wr_rd(slot_wr_rd), .slot_wdata(slot_wdata),
        .slot_rdata(slot_rdata), .slot_flag(slot_flag),
        .count(count), .full(full), .empty(empty), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Slot bank: stores on write enable, drives the read bus the cycle after a read enable.
    logic [DW-1:0]    smem [DEPTH];
    logic [DEPTH-1:0] sflag = '0;
    logic             rd_vld = 1'b0;
    logic [DW-1:0]    rd_word = '0;
    logic             bad_wr = 1'b0, bad_rd = 1'b0;

    always @(posedge clk) begin
        rd_vld <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_en[i]) begin
                if (slot_wr_rd) begin
                    smem[i]  <= slot_wdata;
                    sflag[i] <= !bad_wr;
                end else begin
                    rd_word  <= smem[i];
                    rd_vld   <= 1'b1;
                    sflag[i] <= bad_rd;
                end
            end
        end
    end
    assign slot_rdata = rd_vld ? rd_word : 16'hDEAD;
    assign slot_flag  = sflag;

    int errors = 0, checks = 0;
    int pv_seen = 0, exp_pv = 0;
    int wptr = 0, rptr = 0;
    logic [DW-1:0] q[$];

    always @(negedge clk) if (pop_valid === 1'b1) pv_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DEPTH-1:0] onehot(input int p);
        logic [DEPTH-1:0] v;
        v = '0;
        v[p % DEPTH] = 1'b1;
        return v;
    endfunction

    task automatic push_word(input logic [DW-1:0] v);
        int n;
        @(negedge clk);
        push_data = v;
        push = 1'b1;
        #1;
        n = 0;
        while (!push_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("push_wait", 0, 1);
            push = 1'b0;
            return;
        end
        @(posedge clk);
        q.push_back(v);
        #1;
        push = 1'b0;
        chk("wr_en", slot_en, onehot(wptr));
        chk("wr_sel", slot_wr_rd, 1);
        chk("wr_data", slot_wdata, v);
        chk("wr_count", count, q.size());
        chk("wr_full", full, q.size() == DEPTH);
        chk("wr_empty", empty, 0);
        wptr = (wptr + 1) % DEPTH;
        @(posedge clk);
        #1;
        chk("wr_en_off", slot_en, 0);
    endtask

    task automatic pop_word();
        int n;
        logic [DW-1:0] e;
        @(negedge clk);
        pop = 1'b1;
        #1;
        n = 0;
        while (!pop_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("pop_wait", 0, 1);
            pop = 1'b0;
            return;
        end
        @(posedge clk);
        e = q.pop_front();
        exp_pv++;
        #1;
        pop = 1'b0;
        chk("rd_en", slot_en, onehot(rptr));
        chk("rd_sel", slot_wr_rd, 0);
        chk("rd_count", count, q.size());
        chk("rd_empty", empty, q.size() == 0);
        chk("rd_busy", pop_ready, 0);
        chk("rd_pv_early", pop_valid, 0);
        rptr = (rptr + 1) % DEPTH;
        @(posedge clk);
        #1;
        chk("rd_en_off", slot_en, 0);
        chk("rd_pv_e1", pop_valid, 0);
        @(posedge clk);
        #1;
        chk("rd_pv", pop_valid, 1);
        chk("rd_data", pop_data, e);
        chk("rd_rdy_back", pop_ready, q.size() != 0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] e;
        rst = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_pv", pop_valid, 0);
        chk("rst_pdata", pop_data, 0);
        chk("rst_en", slot_en, 0);
        chk("rst_sel", slot_wr_rd, 0);
        chk("rst_wdata", slot_wdata, 0);
        chk("rst_push_rdy", push_ready, 1);
        chk("rst_pop_rdy", pop_ready, 0);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) push_word(DW'(16'h1111 * (i + 1)));
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        chk("fill_push_rdy", push_ready, 0);
        for (int i = 0; i < 4; i++) pop_word();
        chk("drain_empty", empty, 1);
        chk("drain_err", err, 0);

        for (int i = 0; i < 6; i++) begin
            push_word(DW'(16'hA0 + i));
            chk("wrap_cnt1", count, 1);
            pop_word();
            chk("wrap_cnt0", count, 0);
        end

        // Simultaneous push and pop at count 2: pop first, push follows.
        push_word(16'h0B01);
        push_word(16'h0B02);
        @(negedge clk);
        push_data = 16'hBEEF; push = 1'b1; pop = 1'b1;
        #1;
        chk("sim_push_rdy", push_ready, 0);
        chk("sim_pop_rdy", pop_ready, 1);
        @(posedge clk);
        e = q.pop_front();
        exp_pv++;
        #1;
        pop = 1'b0;
        chk("sim_rd_en", slot_en, onehot(rptr));
        chk("sim_rd_sel", slot_wr_rd, 0);
        chk("sim_cnt1", count, 1);
        rptr = (rptr + 1) % DEPTH;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("sim_pv", pop_valid, 1);
        chk("sim_data", pop_data, e);
        @(posedge clk);
        q.push_back(16'hBEEF);
        #1;
        push = 1'b0;
        chk("sim_wr_en", slot_en, onehot(wptr));
        chk("sim_wr_sel", slot_wr_rd, 1);
        chk("sim_cnt2", count, 2);
        wptr = (wptr + 1) % DEPTH;
        @(posedge clk);
        #1;
        chk("sim_err", err, 0);
        pop_word();
        pop_word();

        // Pop held while empty.
        @(negedge clk);
        pop = 1'b1;
        #1;
        chk("ue_pop_rdy", pop_ready, 0);
        repeat (2) @(negedge clk);
        pop = 1'b0;
        chk("ue_count", count, 0);
        chk("ue_en", slot_en, 0);
        chk("ue_err", err, 1);
        clear_err();
        chk("ue_clr", err, 0);
        @(negedge clk);
        pop = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        pop = 1'b0; err_clr = 1'b0;
        chk("clr_prio", err, 0);

        // Push held while full.
        for (int i = 0; i < 4; i++) push_word(DW'(16'hC000 + i));
        @(negedge clk);
        push_data = 16'h7777; push = 1'b1;
        #1;
        chk("of_push_rdy", push_ready, 0);
        repeat (2) @(negedge clk);
        push = 1'b0;
        chk("of_count", count, 4);
        chk("of_err", err, 1);
        clear_err();
        chk("of_clr", err, 0);
        for (int i = 0; i < 4; i++) pop_word();

        // Slot flag faults.
        bad_wr = 1'b1;
        push_word(16'h5A5A);
        bad_wr = 1'b0;
        chk("fw_err_pre", err, 0);
        @(posedge clk);
        #1;
        chk("fw_err", err, 1);
        clear_err();
        chk("fw_clr", err, 0);
        bad_rd = 1'b1;
        pop_word();
        bad_rd = 1'b0;
        chk("fr_err", err, 1);
        clear_err();

        // Reset while a read is in flight.
        push_word(16'h0D01);
        push_word(16'h0D02);
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        chk("mr_en_on", slot_en, onehot(rptr));
        #2;
        rst = 1'b0;
        #1;
        chk("mr_en_off", slot_en, 0);
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1);
        q.delete();
        wptr = 0;
        rptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_no_pv", pv_seen, exp_pv);

        // Randomized legal traffic.
        for (int i = 0; i < 150; i++) begin
            if (q.size() == DEPTH || (q.size() != 0 && $urandom_range(0, 1) == 1)) pop_word();
            else push_word(DW'($urandom));
        end
        while (q.size() != 0) pop_word();
        repeat (3) @(negedge clk);
        chk("end_count", count, 0);
        chk("end_err", err, 0);
        chk("end_pv", pv_seen, exp_pv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
